tag_memory_lru: RTL

Parametrised set-associative tag store with true-LRU replacement, valid and dirty tracking, and a registered lookup/fill/invalidate command port. It is the next-generation tag memory for the cache controller: it accepts one command per clock, reports hit way or eviction victim one cycle later, and optionally walks the whole array to report dirty lines for write-back.

---
 rtl/tag_memory_lru.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/tag_memory_lru.sv
// Set-associative tag store with true-LRU ages, valid/dirty tracking and a registered command port.
// Define TAGMEM_FLUSH_EN to build the dirty-line flush scanner; otherwise the flush port is inert.
module tag_memory_lru #(
    parameter int TAG_W   = 8,
    parameter int INDEX_W = 4,
    parameter int WAY_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               look,
    input  logic               wr,
    input  logic               inval,
    input  logic [TAG_W-1:0]   tag_in,
    input  logic [INDEX_W-1:0] index,
    input  logic               mod_in,
    output logic               ready,
    output logic               resp_valid,
    output logic               hit,
    output logic [WAY_W-1:0]   chan,
    output logic               age_valid,
    output logic [WAY_W-1:0]   age_chan,
    output logic [TAG_W-1:0]   age_tag,
    output logic               age_mod,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               flush_valid,
    output logic [INDEX_W-1:0] flush_index,
    output logic [WAY_W-1:0]   flush_chan,
    output logic [TAG_W-1:0]   flush_tag
);

    localparam int SETS = 1 << INDEX_W;
    localparam int WAYS = 1 << WAY_W;
    localparam logic [WAY_W-1:0] LRU_AGE = WAY_W'(WAYS - 1);

    logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
    logic             valid_mem [SETS][WAYS];
    logic             dirty_mem [SETS][WAYS];
    logic [WAY_W-1:0] age_mem   [SETS][WAYS];

    logic             do_wr;
    logic             do_look;
    logic             do_inval;
    logic             cmd_any;
    logic             hit_found;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim_way;
    logic             do_touch;
    logic [WAY_W-1:0] touch_way;
    logic [WAY_W-1:0] touch_age;

    // Command priority: wr over look over inval; nothing is accepted while a flush holds ready low.
    assign do_wr    = ready & wr;
    assign do_look  = ready & look & ~wr;
    assign do_inval = ready & inval & ~wr & ~look;
    assign cmd_any  = do_wr | do_look | do_inval;

    always_comb begin
        // NOTE: every combinational output gets a default before the loop so no latch is inferred.
        hit_found = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_found && valid_mem[index][w] && (tag_mem[index][w] == tag_in)) begin
                hit_found = 1'b1;
                hit_way   = WAY_W'(w);
            end
            if (!inv_found && !valid_mem[index][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_mem[index][w] == LRU_AGE) begin
                lru_way = WAY_W'(w);
            end
        end
    end

    assign victim_way = inv_found ? inv_way : lru_way;
    assign do_touch   = do_wr | (do_look & hit_found);
    assign touch_way  = (do_wr && !hit_found) ? victim_way : hit_way;
    assign touch_age  = age_mem[index][touch_way];

`ifdef TAGMEM_FLUSH_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]               flush_state;
    logic [INDEX_W+WAY_W-1:0] scan_ptr;
    logic [INDEX_W-1:0]       scan_set;
    logic [WAY_W-1:0]         scan_way;
    logic                     flush_start;

    assign scan_set    = scan_ptr[INDEX_W+WAY_W-1:WAY_W];
    assign scan_way    = scan_ptr[WAY_W-1:0];
    assign flush_start = ready & flush_req & ~cmd_any;
    assign ready       = (flush_state == ST_IDLE);
    assign flush_busy  = (flush_state == ST_SCAN);
`else
    logic unused_flush;

    assign unused_flush = flush_req;
    assign ready        = 1'b1;
    assign flush_busy   = 1'b0;
    assign flush_valid  = 1'b0;
    assign flush_index  = '0;
    assign flush_chan   = '0;
    assign flush_tag    = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the line state lives in flops, so every entry is cleared by reset; a RAM macro could not be.
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_mem[s][w]   <= '0;
                    valid_mem[s][w] <= 1'b0;
                    dirty_mem[s][w] <= 1'b0;
                    age_mem[s][w]   <= WAY_W'(w);
                end
            end
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            chan       <= '0;
            age_valid  <= 1'b0;
            age_chan   <= '0;
            age_tag    <= '0;
            age_mod    <= 1'b0;
`ifdef TAGMEM_FLUSH_EN
            flush_state <= ST_IDLE;
            scan_ptr    <= '0;
            flush_valid <= 1'b0;
            flush_index <= '0;
            flush_chan  <= '0;
            flush_tag   <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
            resp_valid <= cmd_any;

            if (do_touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way) begin
                        age_mem[index][w] <= '0;
                    end else if (age_mem[index][w] < touch_age) begin
                        age_mem[index][w] <= age_mem[index][w] + 1'b1;
                    end
                end
            end

            if (do_wr) begin
                if (hit_found) begin
                    dirty_mem[index][hit_way] <= dirty_mem[index][hit_way] | mod_in;
                    hit       <= 1'b1;
                    chan      <= hit_way;
                    age_valid <= 1'b0;
                end else begin
                    tag_mem[index][victim_way]   <= tag_in;
                    valid_mem[index][victim_way] <= 1'b1;
                    dirty_mem[index][victim_way] <= mod_in;
                    hit       <= 1'b0;
                    chan      <= victim_way;
                    age_valid <= valid_mem[index][victim_way];
                    if (valid_mem[index][victim_way]) begin
                        age_chan <= victim_way;
                        age_tag  <= tag_mem[index][victim_way];
                        age_mod  <= dirty_mem[index][victim_way];
                    end
                end
            end else if (do_look) begin
                if (hit_found) begin
                    dirty_mem[index][hit_way] <= dirty_mem[index][hit_way] | mod_in;
                end
                hit       <= hit_found;
                chan      <= hit_found ? hit_way : '0;
                age_valid <= 1'b0;
            end else if (do_inval) begin
                if (hit_found) begin
                    valid_mem[index][hit_way] <= 1'b0;
                    dirty_mem[index][hit_way] <= 1'b0;
                end
                hit       <= hit_found;
                chan      <= hit_found ? hit_way : '0;
                age_valid <= 1'b0;
            end

`ifdef TAGMEM_FLUSH_EN
            if (flush_state == ST_SCAN) begin
                flush_valid <= valid_mem[scan_set][scan_way] & dirty_mem[scan_set][scan_way];
                if (valid_mem[scan_set][scan_way] && dirty_mem[scan_set][scan_way]) begin
                    dirty_mem[scan_set][scan_way] <= 1'b0;
                    flush_index <= scan_set;
                    flush_chan  <= scan_way;
                    flush_tag   <= tag_mem[scan_set][scan_way];
                end
                if (scan_ptr == '1) begin
                    flush_state <= ST_IDLE;
                    scan_ptr    <= '0;
                end else begin
                    scan_ptr <= scan_ptr + 1'b1;
                end
            end else begin
                flush_valid <= 1'b0;
                if (flush_start) begin
                    flush_state <= ST_SCAN;
                    scan_ptr    <= '0;
                end
            end
`endif
        end
    end

endmodule
